// File: rtl/ula_ctrl.sv
// ula_ctrl: handshake front-end for a combinational ULA (sum/multiply): registers operands, captures result, counts sum overflows
//   clk, rst_n (async active-low)
//   in_valid/in_ready, op_a, op_b, op_sel : request side (op_sel 0 = sum, 1 = multiply)
//   A, B, SEL : registered operands/selector driven to the ULA; C, overflow : ULA result
//   res_valid/res_ready, res, res_ovf : captured result side
//   ovf_cnt : saturating count of overflowing sums
module ula_ctrl #(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          op_a,
  input  logic [15:0]          op_b,
  input  logic                 op_sel,
  output logic [15:0]          A,
  output logic [15:0]          B,
  output logic                 SEL,
  input  logic [15:0]          C,
  input  logic                 overflow,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res,
  output logic                 res_ovf,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, state_nx;
  logic acc;
  // A draining HOLD may take the next request in the same cycle, keeping one op per two cycles
  assign in_ready = rst_n && (state == IDLE || (state == HOLD && res_ready));
  assign acc = in_valid && in_ready;
  assign res_valid = state == HOLD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = acc ? EXEC : state == EXEC ? HOLD : (state == HOLD && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      A <= '0;
      B <= '0;
      SEL <= 1'b0;
      res <= '0;
      res_ovf <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      if (acc) begin
        A <= op_a;
        B <= op_b;
        SEL <= op_sel;
      end
      if (state == EXEC) begin
        res <= C;
        res_ovf <= overflow && !SEL;
        if (overflow && !SEL && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
      end
    end
endmodule

// File: doc/ula_ctrl.md
ULA_CTRL -- requirements
Module: ula_ctrl

Interface
REQ-001 SHALL have parameter OVF_CNT_W, default 8, meaning width of the saturating overflow counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op_a, op_b  input  16 each  operands.
REQ-007 SHALL have port op_sel  input  1  0 = sum, 1 = multiply.
REQ-008 SHALL have port A, B  output  16 each  registered operands driven to the ULA.
REQ-009 SHALL have port SEL  output  1  registered selector driven to the ULA.
REQ-010 SHALL have port C  input  16  ULA result (combinational from A, B, SEL).
REQ-011 SHALL have port overflow  input  1  ULA sum overflow.
REQ-012 SHALL have port res_valid  output  1  result available.
REQ-013 SHALL have port res_ready  input  1  consumer accepts result.
REQ-014 SHALL have port res  output  16  captured result.
REQ-015 SHALL have port res_ovf  output  1  captured overflow; always 0 for multiply.
REQ-016 SHALL have port ovf_cnt  output  OVF_CNT_W  count of sum operations that overflowed.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-018 IDLE: in_ready=1; on in_valid=1, SHALL load A<=op_a, B<=op_b, SEL<=op_sel and go to EXEC.
REQ-019 EXEC: in_ready=0; SHALL capture res<=C and res_ovf<=overflow & ~SEL, set res_valid=1, go to HOLD (operand-to-result latency exactly 2 cycles after the accepting edge counts as 1 edge to EXEC, 1 edge to HOLD).
REQ-020 EXEC: when SEL=0 and overflow=1, ovf_cnt SHALL increment by 1, saturating at all-ones (no wrap).
REQ-021 HOLD: res, res_ovf, A, B, SEL SHALL remain stable while res_valid=1 and res_ready=0.
REQ-022 HOLD with res_ready=1: SHALL clear res_valid; if in_valid=1 in the same cycle, SHALL accept the new request (in_ready=1 combinationally in HOLD when res_ready=1) and go to EXEC; otherwise go to IDLE.
REQ-023 in_ready SHALL be 1 in IDLE, res_ready in HOLD, 0 in EXEC; no request SHALL be accepted when in_ready=0.
REQ-024 Sustained throughput with res_ready held 1 and in_valid held 1 SHALL be one operation per 2 cycles.
REQ-025 Multiply result SHALL be the ULA's 16-bit C unchanged; the block SHALL not widen or re-truncate it.
REQ-026 op_a/op_b/op_sel changes while not accepted SHALL have no effect on A, B, SEL.

Reset
REQ-027 rst_n=0 SHALL immediately (without clock) force state IDLE, A=0, B=0, SEL=0, res=0, res_ovf=0, res_valid=0, ovf_cnt=0.
REQ-028 in_ready SHALL be 0 while rst_n=0 and 1 on the first edge after release.
REQ-029 Reset asserted in EXEC or HOLD SHALL discard the pending result; no res_valid pulse SHALL follow.

Verification
REQ-030 Sum: op_a=0x0003, op_b=0x0004, op_sel=0 -> res=0x0007, res_ovf=0, res_valid 2 edges after accept, ovf_cnt=0.
REQ-031 Sum overflow: op_a=0x7FFF, op_b=0x0001, op_sel=0 -> res=0x8000, res_ovf=1, ovf_cnt=1.
REQ-032 Multiply: op_a=0x0100, op_b=0x0100, op_sel=1 with ULA overflow=anything -> res=0x0000, res_ovf=0, ovf_cnt unchanged.
REQ-033 Backpressure: res_ready=0 for 5 cycles with in_valid=1 and changing operands -> in_ready=0, res/A/B stable; on res_ready=1 next request accepted same cycle.
REQ-034 Saturation: 260 overflowing sums with OVF_CNT_W=8 -> ovf_cnt=0xFF, stays 0xFF.
REQ-035 Reset mid-HOLD: rst_n pulsed low while res_valid=1 -> all outputs 0 asynchronously, no stale result after release.
